ysyx_24100006_wbu: RTL and testbench
====================================

// Module: ysyx_24100006_wbu
// PURPOSE
// Write-back unit of the multi-cycle NPC core; sits directly upstream of the register file.
// - Accepts one executed instruction from EXU over a valid/ready handshake.
// - For loads, waits for LSU read data, then aligns and sign/zero-extends it.
// - Drives the register-file write port (wen/waddr/wdata) and a one-cycle commit pulse for difftest.
// PARAMETERS
// ADDR_WIDTH  5   register index width; must match the register file
// DATA_WIDTH  32  datapath width (RV32)
// PORTS
// clk             in   1   core clock; all state changes on posedge
// reset           in   1   synchronous, active-high reset
// in_valid        in   1   EXU result valid
// in_ready        out  1   WBU can accept an EXU result
// in_pc           in   32  PC of the incoming instruction
// in_rd           in   5   destination register index
// in_rd_wen       in   1   instruction writes rd
// in_alu_result   in   32  non-load write-back value
// in_is_load      in   1   instruction is a load
// in_load_funct3  in   3   load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
// in_addr_lo      in   2   load address bits [1:0]
// mem_rvalid      in   1   LSU read data valid
// mem_rready      out  1   WBU waiting for LSU read data
// mem_rdata       in   32  raw aligned 32-bit word from memory
// rf_wen          out  1   register-file write enable
// rf_waddr        out  5   register-file write index
// rf_wdata        out  32  register-file write data
// commit_valid    out  1   one-cycle pulse: instruction retired
// commit_pc       out  32  PC of the retiring instruction
// BEHAVIOUR
// - FSM states: IDLE, WAIT_MEM, COMMIT. Reset -> IDLE.
// - Reset also clears all latched fields and the result register.
// - Outputs during and after reset: rf_wen=0, rf_waddr=0, rf_wdata=0, commit_valid=0, commit_pc=0,
//   mem_rready=0, in_ready=1.
// - IDLE:
//   - in_ready=1, mem_rready=0.
//   - On in_valid, latch pc, rd, rd_wen, funct3, addr_lo and alu_result.
//   - If is_load -> WAIT_MEM; otherwise result := alu_result -> COMMIT.
// - WAIT_MEM:
//   - in_ready=0, mem_rready=1.
//   - On mem_rvalid, result := fmt(mem_rdata) -> COMMIT.
//   - Stays in WAIT_MEM indefinitely while mem_rvalid=0.
// - COMMIT (exactly 1 cycle):
//   - in_ready=0, mem_rready=0, commit_valid=1, commit_pc=latched pc.
//   - rf_waddr=latched rd, rf_wdata=result.
//   - rf_wen = latched rd_wen && (rd != 0).
//   - Next state is IDLE.
// - All rf_* and commit_* outputs are driven only from state and registers, never combinationally from in_*/mem_*.
// - rf_wen, rf_waddr, rf_wdata and commit_pc are 0 outside COMMIT.
// - Latency: a non-load writes the cycle after acceptance; a load writes the cycle after mem_rvalid.
//   Throughput is at most one instruction per 2 cycles.
// - fmt(mem_rdata):
//   - byte = rdata[8*addr_lo +: 8]; half = addr_lo[1] ? rdata[31:16] : rdata[15:0].
//   - lb sign-extends byte, lbu zero-extends byte.
//   - lh sign-extends half, lhu zero-extends half; addr_lo[0] is ignored for half loads.
//   - lw uses rdata unchanged, addr_lo ignored.
//   - Undefined funct3 (011, 110, 111) is treated as lw.
// - mem_rvalid in IDLE or COMMIT is ignored: no state change, no write.
// - in_valid while in_ready=0 is ignored. EXU must hold it until handshake.
// - in_rd_wen=0 (stores, branches): rf_wen=0 but commit_valid still pulses.
// - rd=0: rf_wen forced 0 and commit_valid still pulses.
// - Reset in any state, including WAIT_MEM, returns to IDLE next cycle.
//   The pending instruction is dropped: no rf write, no commit.
// TESTING
// - ALU op: in_valid, pc=0x80000000, rd=5, wen=1, alu=0x12345678 -> next cycle rf_wen=1, waddr=5,
//   wdata=0x12345678, commit_valid=1, commit_pc=0x80000000; in_ready=0 that cycle, 1 after.
// - Byte loads, rdata=0x80FF7F01: lb addr_lo=3 -> 0xFFFFFF80; lbu addr_lo=3 -> 0x00000080;
//   lb addr_lo=1 -> 0x0000007F.
// - Half/word loads, rdata=0x80011234: lh addr_lo=2 -> 0xFFFF8001; lhu addr_lo=2 -> 0x00008001;
//   lh addr_lo=0 -> 0x00001234; lw -> 0x80011234.
// - Slow memory: load accepted, mem_rvalid delayed 5 cycles -> mem_rready=1 and in_ready=0 for
//   all 5 cycles; exactly one rf write, the cycle after mem_rvalid.
// - rd=0 with wen=1 and alu=0xDEADBEEF -> rf_wen stays 0, commit_valid=1 for one cycle.
//   Stray mem_rvalid in IDLE -> no output change.
// - reset=1 for 1 cycle while in WAIT_MEM -> IDLE next cycle, in_ready=1, mem_rready=0.
//   A following mem_rvalid produces no rf_wen and no commit_valid.

Source files
------------

// File: rtl/ysyx_24100006_wbu.sv
// Write-back unit: takes one executed instruction from EXU, waits for LSU
// read data on loads, formats it, then drives the register-file write port
// and a one-cycle commit pulse.
module ysyx_24100006_wbu #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic                  in_is_load,
    input  logic [2:0]            in_load_funct3,
    input  logic [1:0]            in_addr_lo,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  commit_valid,
    output logic [DATA_WIDTH-1:0] commit_pc
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                  rd_wen_q, rd_wen_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  in_ready_d, mem_rready_d, rf_wen_d, commit_valid_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_d, commit_pc_d;

    // Align and extend a raw memory word according to the load type.
    function automatic logic [DATA_WIDTH-1:0] fmt(
        input logic [2:0]            f3,
        input logic [1:0]            alo,
        input logic [DATA_WIDTH-1:0] rdata
    );
        logic [BYTE_W-1:0] b;
        logic [HALF_W-1:0] h;
        case (alo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = alo[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  fmt = {{(DATA_WIDTH-BYTE_W){b[BYTE_W-1]}}, b};
            3'b001:  fmt = {{(DATA_WIDTH-HALF_W){h[HALF_W-1]}}, h};
            3'b100:  fmt = {{(DATA_WIDTH-BYTE_W){1'b0}}, b};
            3'b101:  fmt = {{(DATA_WIDTH-HALF_W){1'b0}}, h};
            default: fmt = rdata;
        endcase
    endfunction

    // Next-state, field capture and next registered-output values.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        rd_wen_d  = rd_wen_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pc_d      = in_pc;
                    rd_d      = in_rd;
                    rd_wen_d  = in_rd_wen;
                    funct3_d  = in_load_funct3;
                    addr_lo_d = in_addr_lo;
                    result_d  = in_alu_result;
                    state_d   = in_is_load ? WAIT_MEM : COMMIT;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    result_d = fmt(funct3_q, addr_lo_q, mem_rdata);
                    state_d  = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d     = (state_d == IDLE);
        mem_rready_d   = (state_d == WAIT_MEM);
        commit_valid_d = (state_d == COMMIT);
        rf_wen_d       = commit_valid_d && rd_wen_d && (rd_d != '0);
        rf_waddr_d     = commit_valid_d ? rd_d : '0;
        rf_wdata_d     = commit_valid_d ? result_d : '0;
        commit_pc_d    = commit_valid_d ? pc_d : '0;
    end

    // State, latched fields and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            rd_q         <= '0;
            rd_wen_q     <= 1'b0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            result_q     <= '0;
            in_ready     <= 1'b1;
            mem_rready   <= 1'b0;
            rf_wen       <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rd_q         <= rd_d;
            rd_wen_q     <= rd_wen_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            result_q     <= result_d;
            in_ready     <= in_ready_d;
            mem_rready   <= mem_rready_d;
            rf_wen       <= rf_wen_d;
            rf_waddr     <= rf_waddr_d;
            rf_wdata     <= rf_wdata_d;
            commit_valid <= commit_valid_d;
            commit_pc    <= commit_pc_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_wbu.sv
// Testbench for ysyx_24100006_wbu: directed literal cases plus randomized
// per-cycle stimulus, all checked against a transaction-level model.
module tb_ysyx_24100006_wbu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [31:0] in_alu_result;
    logic        in_is_load;
    logic [2:0]  in_load_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;

    int tests = 0;
    int fails = 0;
    int writes = 0;
    bit en = 1'b0;

    always #5 clk = ~clk;

    ysyx_24100006_wbu dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .in_alu_result(in_alu_result), .in_is_load(in_is_load),
        .in_load_funct3(in_load_funct3), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load formatting using shifts and masks.
    function automatic logic [31:0] fmt_ref(input logic [2:0] f3, input logic [1:0] alo,
                                            input logic [31:0] rdata);
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: begin
                v = (rdata >> (8 * alo)) & 32'h0000_00FF;
                if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                v = (rdata >> (alo[1] ? 16 : 0)) & 32'h0000_FFFF;
                if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    // Transaction-level model: one instruction in flight, retiring for one cycle.
    bit          m_wait, commit_now;
    logic [31:0] s_pc, c_data;
    logic [4:0]  s_rd;
    logic        s_wen;
    logic [2:0]  s_f3;
    logic [1:0]  s_alo;
    logic        e_in_ready, e_mem_rready, e_cv, e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_pc;

    always @(posedge clk) begin
        if (reset) begin
            m_wait = 1'b0; e_cv = 1'b0; e_wen = 1'b0; e_waddr = '0; e_wdata = '0;
            e_pc = '0; e_mem_rready = 1'b0; e_in_ready = 1'b1;
            s_pc = '0; s_rd = '0; s_wen = 1'b0; s_f3 = '0; s_alo = '0;
        end else begin
            commit_now = 1'b0;
            c_data = '0;
            if (e_cv) begin
                commit_now = 1'b0;
            end else if (m_wait) begin
                if (mem_rvalid) begin
                    m_wait = 1'b0;
                    commit_now = 1'b1;
                    c_data = fmt_ref(s_f3, s_alo, mem_rdata);
                end
            end else if (in_valid) begin
                s_pc = in_pc; s_rd = in_rd; s_wen = in_rd_wen;
                s_f3 = in_load_funct3; s_alo = in_addr_lo;
                if (in_is_load) m_wait = 1'b1;
                else begin
                    commit_now = 1'b1;
                    c_data = in_alu_result;
                end
            end
            e_cv         = commit_now;
            e_pc         = commit_now ? s_pc : 32'h0;
            e_wen        = commit_now && s_wen && (s_rd != 5'd0);
            e_waddr      = commit_now ? s_rd : 5'd0;
            e_wdata      = commit_now ? c_data : 32'h0;
            e_mem_rready = m_wait;
            e_in_ready   = !m_wait && !commit_now;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (en) begin
            chk("model_in_ready", 32'(in_ready), 32'(e_in_ready));
            chk("model_mem_rready", 32'(mem_rready), 32'(e_mem_rready));
            chk("model_commit_valid", 32'(commit_valid), 32'(e_cv));
            chk("model_commit_pc", commit_pc, e_pc);
            chk("model_rf_wen", 32'(rf_wen), 32'(e_wen));
            chk("model_rf_waddr", 32'(rf_waddr), 32'(e_waddr));
            chk("model_rf_wdata", rf_wdata, e_wdata);
        end
    end

    always @(negedge clk) if (rf_wen === 1'b1) writes++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle; DUT must be idle beforehand.
    task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                         input logic [31:0] alu, input logic ld, input logic [2:0] f3,
                         input logic [1:0] alo);
        step();
        in_valid = 1'b1; in_pc = pc; in_rd = rd; in_rd_wen = wen; in_alu_result = alu;
        in_is_load = ld; in_load_funct3 = f3; in_addr_lo = alo;
        step();
        in_valid = 1'b0;
    endtask

    task automatic load_test(input string name, input logic [2:0] f3, input logic [1:0] alo,
                             input logic [31:0] rdata, input int delay, input logic [31:0] exp);
        int w0;
        issue(32'h8000_0100, 5'd7, 1'b1, 32'hAAAA_5555, 1'b1, f3, alo);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({name, "_wait_mem_rready"}, 32'(mem_rready), 32'd1);
            chk({name, "_wait_in_ready"}, 32'(in_ready), 32'd0);
            step();
        end
        w0 = writes;
        mem_rvalid = 1'b1; mem_rdata = rdata;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        chk({name, "_wdata"}, rf_wdata, exp);
        chk({name, "_wen"}, 32'(rf_wen), 32'd1);
        step();
        @(negedge clk);
        #1;
        chk({name, "_one_write"}, 32'(writes - w0), 32'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_rd = '0; in_rd_wen = 1'b0;
        in_alu_result = '0; in_is_load = 1'b0; in_load_funct3 = '0; in_addr_lo = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        @(posedge clk);
        #1;
        en = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_rready", 32'(mem_rready), 32'd0);
        chk("rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("rst_commit", 32'(commit_valid), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);

        // ALU instruction
        issue(32'h8000_0000, 5'd5, 1'b1, 32'h1234_5678, 1'b0, 3'b000, 2'd0);
        @(negedge clk);
        chk("alu_wen", 32'(rf_wen), 32'd1);
        chk("alu_waddr", 32'(rf_waddr), 32'd5);
        chk("alu_wdata", rf_wdata, 32'h1234_5678);
        chk("alu_commit", 32'(commit_valid), 32'd1);
        chk("alu_pc", commit_pc, 32'h8000_0000);
        chk("alu_in_ready_busy", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("alu_in_ready_after", 32'(in_ready), 32'd1);
        chk("alu_commit_after", 32'(commit_valid), 32'd0);
        chk("alu_pc_after", commit_pc, 32'd0);

        // Loads with literal expectations
        load_test("lb3",  3'b000, 2'd3, 32'h80FF_7F01, 0, 32'hFFFF_FF80);
        load_test("lbu3", 3'b100, 2'd3, 32'h80FF_7F01, 1, 32'h0000_0080);
        load_test("lb1",  3'b000, 2'd1, 32'h80FF_7F01, 0, 32'h0000_007F);
        load_test("lh2",  3'b001, 2'd2, 32'h8001_1234, 0, 32'hFFFF_8001);
        load_test("lhu3", 3'b101, 2'd3, 32'h8001_1234, 2, 32'h0000_8001);
        load_test("lh0",  3'b001, 2'd0, 32'h8001_1234, 0, 32'h0000_1234);
        load_test("lw",   3'b010, 2'd1, 32'h8001_1234, 0, 32'h8001_1234);
        load_test("f3_111", 3'b111, 2'd2, 32'h8001_1234, 0, 32'h8001_1234);
        load_test("slow", 3'b010, 2'd0, 32'hCAFE_F00D, 5, 32'hCAFE_F00D);

        // rd = 0 with write enable
        issue(32'h8000_0200, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3'b000, 2'd0);
        @(negedge clk);
        chk("rd0_wen", 32'(rf_wen), 32'd0);
        chk("rd0_commit", 32'(commit_valid), 32'd1);
        step();
        @(negedge clk);
        chk("rd0_commit_once", 32'(commit_valid), 32'd0);

        // Stray mem_rvalid while idle
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("stray_in_ready", 32'(in_ready), 32'd1);
        chk("stray_rf_wen", 32'(rf_wen), 32'd0);
        chk("stray_commit", 32'(commit_valid), 32'd0);
        chk("stray_mem_rready", 32'(mem_rready), 32'd0);

        // Reset while waiting for memory drops the load
        issue(32'h8000_0300, 5'd9, 1'b1, 32'h0, 1'b1, 3'b010, 2'd0);
        @(negedge clk);
        chk("rstw_pre_mem_rready", 32'(mem_rready), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_in_ready", 32'(in_ready), 32'd1);
        chk("rstw_mem_rready", 32'(mem_rready), 32'd0);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("rstw_rf_wen", 32'(rf_wen), 32'd0);
        chk("rstw_commit", 32'(commit_valid), 32'd0);

        // Randomized per-cycle stimulus; the model checks every cycle
        for (int c = 0; c < 4000; c++) begin
            step();
            reset          = ($urandom_range(0, 79) == 0);
            in_valid       = ($urandom_range(0, 1) == 1);
            in_pc          = $urandom;
            in_rd          = 5'($urandom_range(0, 31));
            in_rd_wen      = ($urandom_range(0, 3) != 0);
            in_alu_result  = $urandom;
            in_is_load     = ($urandom_range(0, 1) == 1);
            in_load_funct3 = 3'($urandom_range(0, 7));
            in_addr_lo     = 2'($urandom_range(0, 3));
            mem_rvalid     = ($urandom_range(0, 4) < 2);
            mem_rdata      = $urandom;
        end
        step();
        reset = 1'b0; in_valid = 1'b0; mem_rvalid = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
